// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame clocked by the device, ACK check.
// The pins are driven only as open-collector pull-downs through the *_oe outputs.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 250,
    parameter int FIRST_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int MAX_TO  = (FIRST_TIMEOUT > BIT_TIMEOUT) ? FIRST_TIMEOUT : BIT_TIMEOUT;
    localparam int MAX_HO  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int T_MAX   = (MAX_TO > MAX_HO) ? MAX_TO : MAX_HO;
    localparam int TIMER_W = $clog2(T_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t               state_q;
    logic [1:0]           clk_sync_q;
    logic [1:0]           data_sync_q;
    logic                 clk_prev_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [3:0]           bitcnt_q;
    logic [8:0]           shreg_q;
    logic                 clk_oe_q;
    logic                 data_oe_q;
    logic                 tx_ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;

    logic clk_s;
    logic data_s;
    logic fall;
    logic timer_tc;

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign fall     = clk_prev_q & ~clk_s;
    // Timers are loaded with the full cycle count and expire on the cycle they read 1.
    assign timer_tc = (timer_q == TIMER_W'(1));

    // Synchronisers reset to the idle-high bus level so reset never fakes a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // tx_ready/busy settle one cycle after a done/error pulse.
                    if (tx_valid && tx_ready_q) begin
                        shreg_q    <= {~^tx_data, tx_data};
                        timer_q    <= TIMER_W'(INHIBIT_CYCLES);
                        clk_oe_q   <= 1'b1;
                        data_oe_q  <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_INHIBIT;
                    end else begin
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end

                S_INHIBIT: begin
                    if (timer_tc) begin
                        data_oe_q <= 1'b1;
                        timer_q   <= TIMER_W'(RTS_CYCLES);
                        state_q   <= S_RTS;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end

                S_RTS: begin
                    if (timer_tc) begin
                        clk_oe_q <= 1'b0;
                        timer_q  <= TIMER_W'(FIRST_TIMEOUT);
                        bitcnt_q <= '0;
                        state_q  <= S_SEND;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end

                S_SEND: begin
                    if (fall) begin
                        timer_q <= TIMER_W'(BIT_TIMEOUT);
                        if (bitcnt_q == 4'd9) begin
                            data_oe_q <= 1'b0;
                            state_q   <= S_ACK;
                        end else begin
                            data_oe_q <= ~shreg_q[bitcnt_q];
                            bitcnt_q  <= bitcnt_q + 4'd1;
                        end
                    end else if (timer_tc) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end

                S_ACK: begin
                    if (fall) begin
                        if (!data_s) begin
                            timer_q <= TIMER_W'(BIT_TIMEOUT);
                            state_q <= S_WAIT_IDLE;
                        end else begin
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= 1'b0;
                            error_q   <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end else if (timer_tc) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (timer_tc) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end

                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on wired-AND pins, directed and random command bytes,
// timeout, missing-ACK and mid-transfer reset scenarios.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int RTS = 8;
    localparam int FTO = 300;
    localparam int BTO = 150;
    localparam int HP  = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;

    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .FIRST_TIMEOUT (FTO),
        .BIT_TIMEOUT   (BTO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    // Open-collector bus: either side pulling low wins.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_dat & ~ps2_data_oe;

    always @(posedge clock) begin
        if (done === 1'b1)                     done_cnt <= done_cnt + 1;
        if (error === 1'b1)                    err_cnt  <= err_cnt + 1;
        if (done === 1'b1 && error === 1'b1)   both_cnt <= both_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic phases(output int inh, output int rts);
        inh = 0;
        rts = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh < INH * 4) begin
            inh++;
            tick(1);
        end
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && rts < RTS * 4) begin
            rts++;
            tick(1);
        end
    endtask

    // One device clock pulse; the device samples data mid-way through the high phase.
    task automatic dev_fall(output logic bit_seen);
        dev_clk = 1'b0;
        tick(HP);
        dev_clk = 1'b1;
        tick(HP / 2);
        bit_seen = ps2_data_in;
        tick(HP / 2);
    endtask

    task automatic do_xfer(input logic [7:0] b, input logic ack_low);
        logic [9:0] seen;
        logic       s;
        int inh, rts, n, d0, e0, ones;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        chk("busy_after_accept", 32'(busy), 1);
        chk("ready_after_accept", 32'(tx_ready), 0);
        phases(inh, rts);
        chk("inhibit_len", inh, INH);
        chk("rts_len", rts, RTS);
        tick(int'($urandom_range(5, 60)));
        chk("start_bit", 32'(ps2_data_in), 0);
        for (int i = 0; i < 10; i++) begin
            dev_fall(s);
            seen[i] = s;
        end
        dev_dat = ack_low ? 1'b0 : 1'b1;
        tick(2);
        dev_clk = 1'b0;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < BTO * 2) begin
            tick(1);
            n++;
            if (n == HP) begin
                dev_clk = 1'b1;
                dev_dat = 1'b1;
            end
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        ones = $countones(b);
        chk("data_byte", 32'(seen[7:0]), 32'(b));
        chk("parity_bit", 32'(seen[8]), (ones % 2 == 0) ? 1 : 0);
        chk("odd_parity", $countones(seen[8:0]) % 2, 1);
        chk("stop_bit", 32'(seen[9]), 1);
        chk("done_pulse", 32'(done), 32'(ack_low));
        chk("error_pulse", 32'(error), 32'(!ack_low));
        chk("ready_during_pulse", 32'(tx_ready), 0);
        chk("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        tick(1);
        chk("ready_after_pulse", 32'(tx_ready), 1);
        chk("busy_after_pulse", 32'(busy), 0);
        chk("pulse_one_cycle", 32'({done, error}), 0);
        tick(2);
        chk("done_count", done_cnt - d0, 32'(ack_low));
        chk("error_count", err_cnt - e0, 32'(!ack_low));
    endtask

    initial begin
        int inh, rts, n, d0, e0;
        logic s;

        tick(3);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        reset = 1'b0;
        tick(3);

        do_xfer(8'hED, 1'b1);
        do_xfer(8'hF4, 1'b1);
        do_xfer(8'h00, 1'b1);
        do_xfer(8'hFF, 1'b1);
        for (int k = 0; k < 3; k++) do_xfer(8'($urandom_range(0, 255)), 1'b1);

        // Device never clocks: error FTO cycles after clk_oe drops.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'($urandom_range(0, 255)));
        phases(inh, rts);
        chk("to1_inhibit_len", inh, INH);
        chk("to1_rts_len", rts, RTS);
        n = 0;
        while (error !== 1'b1 && n < FTO * 2) begin
            tick(1);
            n++;
        end
        chk("first_timeout_cycles", n, FTO);
        chk("to1_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("to1_no_done", 32'(done), 0);
        tick(3);
        chk("to1_done_count", done_cnt - d0, 0);
        chk("to1_error_count", err_cnt - e0, 1);
        chk("to1_ready", 32'(tx_ready), 1);

        // Device stops after 5 falls: error BTO cycles after the 5th fall reaches the FSM
        // (2 synchroniser flops plus the edge-detect register add 3 cycles from the pin).
        start_tx(8'($urandom_range(0, 255)));
        phases(inh, rts);
        tick(20);
        for (int i = 0; i < 4; i++) dev_fall(s);
        dev_clk = 1'b0;
        n = 0;
        while (error !== 1'b1 && n < BTO * 2) begin
            tick(1);
            n++;
            if (n == HP) dev_clk = 1'b1;
        end
        dev_clk = 1'b1;
        chk("bit_timeout_cycles", n, BTO + 3);
        chk("to2_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        tick(3);

        // Device leaves data high at fall 11.
        do_xfer(8'($urandom_range(0, 255)), 1'b0);

        // Second request during busy is ignored; reset at bit 4 aborts quietly.
        start_tx(8'hA5);
        tick(5);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("busy_ignores_valid", 32'(busy), 1);
        phases(inh, rts);
        chk("no_restart_inhibit", inh, INH - 6);
        tick(20);
        for (int i = 0; i < 4; i++) dev_fall(s);
        chk("bit4_still_busy", 32'(busy), 1);
        d0 = done_cnt;
        e0 = err_cnt;
        reset = 1'b1;
        tick(1);
        chk("rst_mid_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_mid_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ready", 32'(tx_ready), 1);
        chk("rst_mid_pulses", 32'({done, error}), 0);
        reset = 1'b0;
        tick(INH + RTS + 40);
        chk("no_second_xfer_clk", 32'(ps2_clk_oe), 0);
        chk("no_second_xfer_busy", 32'(busy), 0);
        chk("rst_mid_done_count", done_cnt - d0, 0);
        chk("rst_mid_error_count", err_cnt - e0, 0);

        chk("done_error_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
